// File: rtl/tdm_mux_n.sv
// Registered N:1 word multiplexer with manual select and round-robin TDM scan.
// Each scanned channel is held for DWELL enabled cycles; wrap marks the end of a full sweep.
module tdm_mux_n #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]          out1,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  output logic                      wrap
);

  localparam int SLOTS = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);
  localparam logic [7:0]       LAST_CNT  = 8'(DWELL - 1);

  logic [WIDTH-1:0] chan [SLOTS];

  logic [WIDTH-1:0] out1_reg, out1_next;
  logic [SEL_W-1:0] out_chan_reg, out_chan_next;
  logic             out_valid_reg, out_valid_next;
  logic             wrap_reg, wrap_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             mode_prev_reg;

  logic [SEL_W-1:0] eff_ptr;
  logic [7:0]       eff_cnt;
  logic             sel_legal;

  // Unused select codes map to zero so every index of chan[] is defined.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_chan
      if (gi < CHANNELS) begin : g_used
        assign chan[gi] = in_bus[gi*WIDTH +: WIDTH];
      end else begin : g_unused
        assign chan[gi] = '0;
      end
    end
  endgenerate

  // Entering scan mode restarts the sweep at channel 0 with a full dwell.
  assign eff_ptr   = mode_prev_reg ? ptr_reg : '0;
  assign eff_cnt   = mode_prev_reg ? cnt_reg : '0;
  assign sel_legal = (32'(sel) < CHANNELS);

  always_comb begin
    out1_next      = out1_reg;
    out_chan_next  = out_chan_reg;
    out_valid_next = 1'b0;
    wrap_next      = 1'b0;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    if (enable) begin
      if (!mode) begin
        ptr_next = '0;
        cnt_next = '0;
        if (sel_legal) begin
          out1_next      = chan[sel];
          out_chan_next  = sel;
          out_valid_next = 1'b1;
        end
      end else begin
        out1_next      = chan[eff_ptr];
        out_chan_next  = eff_ptr;
        out_valid_next = 1'b1;
        wrap_next      = (eff_ptr == LAST_CHAN) && (eff_cnt == LAST_CNT);
        if (eff_cnt == LAST_CNT) begin
          cnt_next = '0;
          ptr_next = (eff_ptr == LAST_CHAN) ? '0 : eff_ptr + 1'b1;
        end else begin
          cnt_next = eff_cnt + 8'd1;
          ptr_next = eff_ptr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out1_reg      <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      wrap_reg      <= 1'b0;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      mode_prev_reg <= 1'b0;
    end else begin
      out1_reg      <= out1_next;
      out_chan_reg  <= out_chan_next;
      out_valid_reg <= out_valid_next;
      wrap_reg      <= wrap_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      mode_prev_reg <= mode;
    end
  end

  assign out1      = out1_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_tdm_mux_n.sv
// Bench for tdm_mux_n: directed vector table, hand sequences on a 3-channel instance,
// and randomized traffic against a sweep-position reference model.
module tb_tdm_mux_n;

  logic        clk = 1'b0;
  logic        reset, enable, mode;
  logic [1:0]  sel;
  logic [15:0] bus;

  logic [3:0]  out1_a, out1_b;
  logic [1:0]  chan_a, chan_b;
  logic        valid_a, valid_b, wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdm_mux_n #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sel(sel),
    .in_bus(bus), .out1(out1_a), .out_chan(chan_a), .out_valid(valid_a), .wrap(wrap_a)
  );

  tdm_mux_n #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sel(sel),
    .in_bus(bus[11:0]), .out1(out1_b), .out_chan(chan_b), .out_valid(valid_b), .wrap(wrap_b)
  );

  typedef struct {
    bit          rst, en, md;
    logic [1:0]  s;
    logic [15:0] b;
    logic [3:0]  e_out;
    logic [1:0]  e_chan;
    bit          e_valid, e_wrap;
  } vec_t;

  vec_t vq[$];

  // Reference model: scan position is a count of enabled scan cycles since the sweep began.
  logic [3:0] m_out [2];
  int m_chan [2], m_valid [2], m_wrap [2], m_t [2], m_prev [2];

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, idx, checks, act, exp);
    end
  endtask

  task automatic model_step(input int idx, input int nch, input int dw,
                            input bit r, input bit en, input bit md,
                            input int s, input logic [15:0] b);
    int ch;
    if (r) begin
      m_out[idx] = 0; m_chan[idx] = 0; m_valid[idx] = 0; m_wrap[idx] = 0;
      m_t[idx] = 0; m_prev[idx] = 0;
      return;
    end
    m_valid[idx] = 0;
    m_wrap[idx]  = 0;
    if (en) begin
      if (!md) begin
        m_t[idx] = 0;
        if (s < nch) begin
          m_out[idx] = 4'((b >> (4 * s)) & 16'hF);
          m_chan[idx] = s;
          m_valid[idx] = 1;
        end
      end else begin
        if (m_prev[idx] == 0) m_t[idx] = 0;
        ch = m_t[idx] / dw;
        m_out[idx] = 4'((b >> (4 * ch)) & 16'hF);
        m_chan[idx] = ch;
        m_valid[idx] = 1;
        m_wrap[idx] = (m_t[idx] == nch * dw - 1) ? 1 : 0;
        m_t[idx] = (m_t[idx] + 1) % (nch * dw);
      end
    end
    m_prev[idx] = md;
  endtask

  task automatic drive(input bit r, input bit en, input bit md, input logic [1:0] s, input logic [15:0] b);
    reset = r; enable = en; mode = md; sel = s; bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_b(input string nm, input logic [3:0] o, input logic [1:0] c, input bit v, input bit w);
    chk({nm, "_out1"}, 1, 16'(out1_b), 16'(o));
    chk({nm, "_chan"}, 1, 16'(chan_b), 16'(c));
    chk({nm, "_valid"}, 1, 16'(valid_b), 16'(v));
    chk({nm, "_wrap"}, 1, 16'(wrap_b), 16'(w));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; sel = 2'd0; bus = 16'hDCBA;

    // rst en md sel bus | out chan valid wrap
    for (int i = 0; i < 3; i++) vq.push_back('{1, 0, 0, 2'd0, 16'hDCBA, 4'h0, 2'd0, 0, 0});
    vq.push_back('{0, 1, 0, 2'd2, 16'hDCBA, 4'hC, 2'd2, 1, 0});
    vq.push_back('{0, 1, 0, 2'd3, 16'hDCBA, 4'hD, 2'd3, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hA, 2'd0, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hA, 2'd0, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hB, 2'd1, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hB, 2'd1, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hC, 2'd2, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hC, 2'd2, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hD, 2'd3, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hD, 2'd3, 1, 1});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hA, 2'd0, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hA, 2'd0, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hB, 2'd1, 1, 0});
    for (int i = 0; i < 3; i++) vq.push_back('{0, 0, 1, 2'd0, 16'hDCBA, 4'hB, 2'd1, 0, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hB, 2'd1, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hC, 2'd2, 1, 0});
    vq.push_back('{1, 1, 1, 2'd0, 16'hDCBA, 4'h0, 2'd0, 0, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hA, 2'd0, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hA, 2'd0, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'hDCBA, 4'hB, 2'd1, 1, 0});
    vq.push_back('{0, 1, 0, 2'd0, 16'hDCBA, 4'hA, 2'd0, 1, 0});
    vq.push_back('{0, 1, 0, 2'd3, 16'hDCBA, 4'hD, 2'd3, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'h1234, 4'h4, 2'd0, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'h5678, 4'h8, 2'd0, 1, 0});
    vq.push_back('{0, 1, 1, 2'd0, 16'h5678, 4'h7, 2'd1, 1, 0});

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].md, vq[i].s, vq[i].b);
      chk($sformatf("vec%0d_out1", i), 0, 16'(out1_a), 16'(vq[i].e_out));
      chk($sformatf("vec%0d_chan", i), 0, 16'(chan_a), 16'(vq[i].e_chan));
      chk($sformatf("vec%0d_valid", i), 0, 16'(valid_a), 16'(vq[i].e_valid));
      chk($sformatf("vec%0d_wrap", i), 0, 16'(wrap_a), 16'(vq[i].e_wrap));
      $display("vec %0d: rst=%0b en=%0b mode=%0b sel=%0d -> out1=%h chan=%0d valid=%0b wrap=%0b",
               i, vq[i].rst, vq[i].en, vq[i].md, vq[i].s, out1_a, chan_a, valid_a, wrap_a);
    end

    // Three-channel instance: illegal select holds, DWELL=1 sweep wraps every third cycle.
    drive(1, 0, 0, 2'd0, 16'h0CBA); expect_b("b_reset", 4'h0, 2'd0, 0, 0);
    drive(0, 1, 0, 2'd1, 16'h0CBA); expect_b("b_sel1", 4'hB, 2'd1, 1, 0);
    drive(0, 1, 0, 2'd3, 16'h0CBA); expect_b("b_illegal", 4'hB, 2'd1, 0, 0);
    drive(0, 1, 1, 2'd3, 16'h0CBA); expect_b("b_scan0", 4'hA, 2'd0, 1, 0);
    drive(0, 1, 1, 2'd3, 16'h0CBA); expect_b("b_scan1", 4'hB, 2'd1, 1, 0);
    drive(0, 1, 1, 2'd3, 16'h0CBA); expect_b("b_scan2", 4'hC, 2'd2, 1, 1);
    drive(0, 1, 1, 2'd3, 16'h0CBA); expect_b("b_scan3", 4'hA, 2'd0, 1, 0);
    $display("seq b: illegal select and DWELL=1 sweep done");

    // Randomized traffic against the reference model, both instances.
    begin
      bit r, en, md;
      logic [1:0] s;
      logic [15:0] b;
      md = 1'b0;
      for (int n = 0; n < 600; n++) begin
        r  = (n == 0) || ($urandom_range(0, 99) < 4);
        en = ($urandom_range(0, 99) < 80);
        if ($urandom_range(0, 99) < 15) md = ~md;
        s  = 2'($urandom_range(0, 3));
        b  = 16'($urandom);
        drive(r, en, md, s, b);
        model_step(0, 4, 2, r, en, md, int'(s), b);
        model_step(1, 3, 1, r, en, md, int'(s), {4'h0, b[11:0]});
        chk("rand_out1", 0, 16'(out1_a), 16'(m_out[0]));
        chk("rand_chan", 0, 16'(chan_a), 16'(m_chan[0]));
        chk("rand_valid", 0, 16'(valid_a), 16'(m_valid[0]));
        chk("rand_wrap", 0, 16'(wrap_a), 16'(m_wrap[0]));
        chk("rand_out1", 1, 16'(out1_b), 16'(m_out[1]));
        chk("rand_chan", 1, 16'(chan_b), 16'(m_chan[1]));
        chk("rand_valid", 1, 16'(valid_b), 16'(m_valid[1]));
        chk("rand_wrap", 1, 16'(wrap_b), 16'(m_wrap[1]));
        $display("rand %0d: rst=%0b en=%0b mode=%0b sel=%0d bus=%h -> a=%h/%0d/%0b/%0b b=%h/%0d/%0b/%0b",
                 n, r, en, md, s, b, out1_a, chan_a, valid_a, wrap_a, out1_b, chan_b, valid_b, wrap_b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux_n.md
Name: tdm_mux_n

Overview:
- Parametrised, registered N:1 multiplexer. Successor to the 2:1 gated mux.
- Selects one of CHANNELS input words of WIDTH bits.
- Selection is either a manual select (mode 0) or an automatic round-robin time-division scan with programmable dwell (mode 1).
- Feeds serial/display paths in later labs, where one output bus is shared across channels.

Parameters:
- WIDTH, 1, bits per channel word.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/index width; must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 1, clock cycles each channel is held in scan mode (1..255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = update outputs this cycle; 0 = freeze.
- mode  input  1  0 = manual select, 1 = auto scan.
- sel  input  SEL_W  channel index used in mode 0.
- in_bus  input  CHANNELS*WIDTH  packed inputs; channel k = bits [k*WIDTH +: WIDTH].
- out1  output  WIDTH  registered selected word.
- out_chan  output  SEL_W  index of the channel currently on out1.
- out_valid  output  1  out1/out_chan were updated with a legal channel this cycle.
- wrap  output  1  one-cycle pulse on the last dwell cycle of channel CHANNELS-1 in scan mode.

Behaviour:
- All state updates on rising clk; reset has priority over every other input.
- Reset values:
  - out1=0, out_chan=0, out_valid=0, wrap=0.
  - Internal scan pointer=0, dwell counter=0, registered previous mode=0.
- Latency: one cycle. Inputs sampled at edge t appear on the outputs after edge t.
- enable=0:
  - out1 and out_chan hold.
  - out_valid=0, wrap=0.
  - Scan pointer and dwell counter frozen; previous-mode register still updates.
- Mode 0 (manual), enable=1:
  - sel < CHANNELS: out1 <= channel[sel], out_chan <= sel, out_valid <= 1.
  - sel >= CHANNELS: out1 and out_chan hold, out_valid <= 0.
  - wrap=0. Dwell counter and scan pointer are cleared to 0.
- Mode 1 (scan), enable=1:
  - out1 <= channel[ptr], out_chan <= ptr, out_valid <= 1.
  - If dwell counter == DWELL-1: counter <= 0; ptr <= ptr+1, or 0 when ptr == CHANNELS-1.
  - Otherwise counter <= counter+1.
  - wrap <= 1 exactly when ptr == CHANNELS-1 and counter == DWELL-1; else 0.
- Mode transitions:
  - 0->1 restarts the scan at ptr=0, counter=0, so the first scan output is channel 0.
  - 1->0 takes effect on the same edge (sel is used immediately).
- DWELL=1: the pointer advances every enabled cycle; wrap fires once per CHANNELS cycles.
- Reset mid-scan: the next enabled scan cycle outputs channel 0 with a full dwell.
- Input changes on the currently selected channel during a dwell are tracked cycle by cycle; the output is not latched per dwell.
- Purely synchronous: no combinational path from inputs to outputs.

Test Plan:
- Reset: bench config CHANNELS=4, WIDTH=4, DWELL=2, in_bus=16'hDCBA. Hold reset 3 cycles -> out1=0, out_chan=0, out_valid=0, wrap=0.
- Manual select: mode=0, enable=1, sel=2 -> after one edge out1=4'hC, out_chan=2, out_valid=1. Then sel=3 -> out1=4'hD.
- Scan sequence: mode=1 from mode 0, 8 cycles -> out1 = A,A,B,B,C,C,D,D. wrap=1 only on the second D cycle. The ninth output is A.
- Freeze mid-scan: enable=0 for 3 cycles during the first B cycle -> out1 holds B, out_valid=0. On re-enable the second B cycle follows, then C.
- Illegal select: CHANNELS=3, mode=0, sel=3 -> out1/out_chan hold the previous value, out_valid=0.
- Reset mid-scan: assert reset while on channel C, release with mode=1 -> the sequence restarts A,A,B; wrap stays 0.
